// File: rtl/game_pkg.sv
// Shared encodings for the two-player guessing game: round results, match winner,
// scoreboard states and the seven-segment blank pattern.
package game_pkg;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_BOTH = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to active-low seven-segment pattern; bit 0 = segment a, bit 6 = segment g.
module seg7_decoder
  import game_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    case (hex)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/game_scoreboard.sv
// Match-level scoreboard: accumulates per-player points, ends the match at WIN_SCORE
// and multiplexes both scores onto a two-digit seven-segment display.
module game_scoreboard
  import game_pkg::*;
#(
  parameter int WIN_SCORE   = 3,
  parameter int SCORE_W     = 4,
  parameter int REFRESH_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               round_valid,
  input  logic [1:0]         result,
  input  logic               new_match,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [7:0]         round_count,
  output logic               match_over,
  output logic [1:0]         winner,
  output logic [6:0]         seg,
  output logic [1:0]         an
);

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam int RW = REFRESH_DIV + 1;

  state_t             state, state_nxt;
  logic [SCORE_W-1:0] s1_nxt, s2_nxt;
  logic [7:0]         rc_nxt;
  logic [1:0]         win_nxt;
  logic [RW-1:0]      refresh, refresh_nxt;
  logic               sel_nxt;
  logic               blank_nxt;
  logic [3:0]         digit_nxt;
  logic [6:0]         seg_dec;

  assign match_over = (state == OVER);

  always_comb begin
    state_nxt = state;
    s1_nxt    = score1;
    s2_nxt    = score2;
    rc_nxt    = round_count;
    win_nxt   = winner;
    if (new_match) begin
      state_nxt = PLAY;
      s1_nxt    = '0;
      s2_nxt    = '0;
      rc_nxt    = '0;
      win_nxt   = WIN_NONE;
    end else if (state == PLAY && round_valid) begin
      rc_nxt = round_count + 8'd1;
      if (result[0] && score1 != WIN) s1_nxt = score1 + SCORE_W'(1);
      if (result[1] && score2 != WIN) s2_nxt = score2 + SCORE_W'(1);
      if (s1_nxt == WIN || s2_nxt == WIN) begin
        state_nxt = OVER;
        win_nxt   = {s2_nxt == WIN, s1_nxt == WIN};
      end
    end
  end

  // The display is decoded from next-state values so that the registered seg
  // always matches the registered an and scores on the same cycle.
  always_comb begin
    refresh_nxt = refresh + RW'(1);
    sel_nxt     = refresh_nxt[RW-1];
    digit_nxt   = sel_nxt ? 4'(s2_nxt) : 4'(s1_nxt);
    blank_nxt   = (state_nxt == OVER) &&
                  (sel_nxt ? (win_nxt == WIN_P1) : (win_nxt == WIN_P2));
    if (!reset) begin
      sel_nxt   = 1'b0;
      digit_nxt = 4'h0;
      blank_nxt = 1'b0;
    end
  end

  seg7_decoder u_dec (
    .hex (digit_nxt),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= PLAY;
      score1      <= '0;
      score2      <= '0;
      round_count <= '0;
      winner      <= WIN_NONE;
      refresh     <= '0;
      an          <= 2'b10;
      seg         <= seg_dec;
    end else begin
      state       <= state_nxt;
      score1      <= s1_nxt;
      score2      <= s2_nxt;
      round_count <= rc_nxt;
      winner      <= win_nxt;
      refresh     <= refresh_nxt;
      an          <= sel_nxt ? 2'b01 : 2'b10;
      seg         <= blank_nxt ? SEG_BLANK : seg_dec;
    end
  end

endmodule

// File: tb/tb_game_scoreboard.sv
// Scoreboard bench for game_scoreboard: directed rounds push expected outputs into a
// queue, and a negedge monitor pops and compares them once the DUT has produced them.
module tb_game_scoreboard;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       round_valid = 1'b0;
  logic [1:0] result = 2'b00;
  logic       new_match = 1'b0;
  logic [3:0] score1, score2;
  logic [7:0] round_count;
  logic       match_over;
  logic [1:0] winner;
  logic [6:0] seg;
  logic [1:0] an;

  game_scoreboard #(.WIN_SCORE(3), .SCORE_W(4), .REFRESH_DIV(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .round_valid (round_valid),
    .result      (result),
    .new_match   (new_match),
    .score1      (score1),
    .score2      (score2),
    .round_count (round_count),
    .match_over  (match_over),
    .winner      (winner),
    .seg         (seg),
    .an          (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    string      name;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [7:0] rc;
    logic       over;
    logic [1:0] win;
    logic [1:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   ref_cnt = 0;
  int   n_vectors = 0;
  int   n_miscompares = 0;

  // Active-low patterns, bit 0 = segment a
  logic [6:0] seg_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always @(posedge clk) cyc++;

  task automatic applyStimulus(input bit do_rst, input bit rv, input logic [1:0] res,
                               input bit nm, input int e1, input int e2, input int erc,
                               input bit eover, input logic [1:0] ewin, input string name);
    exp_t e;
    int   digit;
    bit   blank;
    @(posedge clk);
    #1;
    reset       = !do_rst;
    round_valid = rv;
    result      = res;
    new_match   = nm;
    ref_cnt = do_rst ? 0 : (ref_cnt + 1) % 8;
    digit   = (ref_cnt >> 2) & 1;
    blank   = eover && (digit == 1 ? (ewin == 2'b01) : (ewin == 2'b10));
    e.due  = cyc + 1;
    e.name = name;
    e.s1   = 4'(e1);
    e.s2   = 4'(e2);
    e.rc   = 8'(erc);
    e.over = eover;
    e.win  = ewin;
    e.an   = (digit == 1) ? 2'b01 : 2'b10;
    e.seg  = blank ? 7'h7F : seg_table[(digit == 1) ? e2 : e1];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input int e1, input int e2, input int erc,
                      input bit eover, input logic [1:0] ewin, input string name);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, RES_NONE, 1'b0, e1, e2, erc, eover, ewin, name);
  endtask

  task automatic checkOutput(input exp_t e);
    n_vectors++;
    if (score1 !== e.s1) begin
      n_miscompares++;
      $display("[TB] FAIL %s score1: got %0d want %0d", e.name, score1, e.s1);
    end
    if (score2 !== e.s2) begin
      n_miscompares++;
      $display("[TB] FAIL %s score2: got %0d want %0d", e.name, score2, e.s2);
    end
    if (round_count !== e.rc) begin
      n_miscompares++;
      $display("[TB] FAIL %s round_count: got %0d want %0d", e.name, round_count, e.rc);
    end
    if (match_over !== e.over) begin
      n_miscompares++;
      $display("[TB] FAIL %s match_over: got %b want %b", e.name, match_over, e.over);
    end
    if (winner !== e.win) begin
      n_miscompares++;
      $display("[TB] FAIL %s winner: got %b want %b", e.name, winner, e.win);
    end
    if (an !== e.an) begin
      n_miscompares++;
      $display("[TB] FAIL %s an: got %b want %b", e.name, an, e.an);
    end
    if (seg !== e.seg) begin
      n_miscompares++;
      $display("[TB] FAIL %s seg: got %b want %b", e.name, seg, e.seg);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e);
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, RES_NONE, 1'b0, 0, 0, 0, 1'b0, 2'b00, "reset0");
    applyStimulus(1'b1, 1'b0, RES_NONE, 1'b0, 0, 0, 0, 1'b0, 2'b00, "reset1");

    // Player 1 wins 3/1, later strobe ignored, loser digit blanked
    applyStimulus(1'b0, 1'b1, RES_P1,   1'b0, 1, 0, 1, 1'b0, 2'b00, "a_r1");
    applyStimulus(1'b0, 1'b1, RES_P1,   1'b0, 2, 0, 2, 1'b0, 2'b00, "a_r2");
    applyStimulus(1'b0, 1'b1, RES_P2,   1'b0, 2, 1, 3, 1'b0, 2'b00, "a_r3");
    applyStimulus(1'b0, 1'b1, RES_P1,   1'b0, 3, 1, 4, 1'b1, 2'b01, "a_win");
    applyStimulus(1'b0, 1'b1, RES_P2,   1'b0, 3, 1, 4, 1'b1, 2'b01, "a_ignored");
    idle(5, 3, 1, 4, 1'b1, 2'b01, "a_hold");
    applyStimulus(1'b0, 1'b0, RES_NONE, 1'b1, 0, 0, 0, 1'b0, 2'b00, "a_newmatch");

    // Draw: both reach 3 on the same round, no blanking
    applyStimulus(1'b0, 1'b1, RES_BOTH, 1'b0, 1, 1, 1, 1'b0, 2'b00, "b_r1");
    applyStimulus(1'b0, 1'b1, RES_BOTH, 1'b0, 2, 2, 2, 1'b0, 2'b00, "b_r2");
    applyStimulus(1'b0, 1'b1, RES_BOTH, 1'b0, 3, 3, 3, 1'b1, 2'b11, "b_draw");
    idle(5, 3, 3, 3, 1'b1, 2'b11, "b_hold");
    applyStimulus(1'b0, 1'b0, RES_NONE, 1'b1, 0, 0, 0, 1'b0, 2'b00, "b_newmatch");

    // new_match beats a simultaneous round
    applyStimulus(1'b0, 1'b1, RES_P2,   1'b0, 0, 1, 1, 1'b0, 2'b00, "c_r1");
    applyStimulus(1'b0, 1'b1, RES_P2,   1'b0, 0, 2, 2, 1'b0, 2'b00, "c_r2");
    applyStimulus(1'b0, 1'b1, RES_P2,   1'b1, 0, 0, 0, 1'b0, 2'b00, "c_nm_wins");
    idle(2, 0, 0, 0, 1'b0, 2'b00, "c_idle");
    applyStimulus(1'b0, 1'b1, RES_P1,   1'b0, 1, 0, 1, 1'b0, 2'b00, "c_play");
    applyStimulus(1'b0, 1'b0, RES_NONE, 1'b1, 0, 0, 0, 1'b0, 2'b00, "c_newmatch");

    // Reset mid-match, with priority over new_match and round_valid
    applyStimulus(1'b0, 1'b1, RES_P1,   1'b0, 1, 0, 1, 1'b0, 2'b00, "d_r1");
    applyStimulus(1'b0, 1'b1, RES_P1,   1'b0, 2, 0, 2, 1'b0, 2'b00, "d_r2");
    applyStimulus(1'b1, 1'b1, RES_P2,   1'b1, 0, 0, 0, 1'b0, 2'b00, "d_reset");
    applyStimulus(1'b0, 1'b1, RES_P2,   1'b0, 0, 1, 1, 1'b0, 2'b00, "d_after");

    // Digit refresh over 16 clocks in PLAY
    idle(16, 0, 1, 1, 1'b0, 2'b00, "e_refresh");
    applyStimulus(1'b0, 1'b0, RES_NONE, 1'b1, 0, 0, 0, 1'b0, 2'b00, "e_newmatch");

    // Rounds with nobody correct still count
    for (int k = 1; k <= 5; k++)
      applyStimulus(1'b0, 1'b1, RES_NONE, 1'b0, 0, 0, k, 1'b0, 2'b00, "f_none");

    // Player 2 wins, player 1 digit blanked
    applyStimulus(1'b0, 1'b1, RES_P2,   1'b0, 0, 1, 6, 1'b0, 2'b00, "g_r1");
    applyStimulus(1'b0, 1'b1, RES_P2,   1'b0, 0, 2, 7, 1'b0, 2'b00, "g_r2");
    applyStimulus(1'b0, 1'b1, RES_P2,   1'b0, 0, 3, 8, 1'b1, 2'b10, "g_p2win");
    idle(8, 0, 3, 8, 1'b1, 2'b10, "g_hold");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      n_miscompares++;
      $display("[TB] FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/game_scoreboard.md
# game_scoreboard

Match-level scoreboard placed directly downstream of the two-player guess-comparison top level. It consumes the per-round 2-bit result, accumulates a score per player, ends the match when a player reaches a target score, and drives a two-digit multiplexed seven-segment display with both scores. Its output is the user-visible match state. Board wiring consumes the display outputs, and a host consumes `match_over`/`winner`.

## Interface
Parameters:
- `WIN_SCORE`, 3: points needed to win a match; legal range 1..15.
- `SCORE_W`, 4: width of each score counter; must satisfy 2^SCORE_W > WIN_SCORE.
- `REFRESH_DIV`, 4: digit-multiplex period is 2^REFRESH_DIV clocks per digit.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `round_valid`  in  1  one-cycle strobe; `result` is valid this cycle.
- `result`  in  2  round outcome: 00 = nobody correct, 01 = player 1 correct, 10 = player 2 correct, 11 = both correct.
- `new_match`  in  1  one-cycle strobe; clears scores and starts a new match.
- `score1`  out  SCORE_W  player 1 score.
- `score2`  out  SCORE_W  player 2 score.
- `round_count`  out  8  rounds accepted in the current match; wraps at 255→0.
- `match_over`  out  1  high while in OVER.
- `winner`  out  2  00 = none, 01 = player 1, 10 = player 2, 11 = draw; valid when `match_over` = 1.
- `seg`  out  7  segments a..g, active-low.
- `an`  out  2  digit enables, active-low; an[0] = score1 digit, an[1] = score2 digit.

## Operation
States are PLAY and OVER. Reset and `new_match` both lead to PLAY.

PLAY, when `round_valid` = 1:
- `round_count` += 1.
- If `result`[0] = 1, `score1` += 1.
- If `result`[1] = 1, `score2` += 1.
- Scores saturate at WIN_SCORE.
- A result of 00 still counts as a round.

Transition from PLAY to OVER happens on the same edge where an updated score reaches WIN_SCORE:
- Only score1 reaches it: `winner` = 01.
- Only score2 reaches it: `winner` = 10.
- Both reach it on the same round (result 11): `winner` = 11 (draw).

OVER:
- `round_valid` is ignored.
- Scores, `round_count` and `winner` hold.
- Exit only on `new_match` or reset.

`new_match`, accepted in either state:
- Next edge: scores = 0, `round_count` = 0, `winner` = 00, state = PLAY.
- If `new_match` and `round_valid` occur in the same cycle, `new_match` wins and the round is dropped.

Display:
- A free-running refresh counter of width REFRESH_DIV+1 runs continuously; its MSB selects the digit.
- The selected score is shown as a hex digit (0–F).
- In OVER, the losing player's digit is blanked (`seg` = 7'b1111111) while that digit is selected. On a draw neither digit is blanked.

## Timing
- Reset values (first edge with `reset` = 0):
  - `score1` = `score2` = 0, `round_count` = 0, `match_over` = 0, `winner` = 00.
  - Refresh counter = 0, `an` = 2'b10 (digit 0 active), `seg` = pattern for "0".
- Reset mid-match clears everything on that edge. Reset has priority over `new_match` and `round_valid`.
- Latency from `round_valid` to updated `score*`, `round_count`, `match_over` and `winner` is 1 clock. All are registered and change on the same edge.
- `seg` and `an` are registered. `seg` always corresponds to the currently enabled digit, with no one-cycle mismatch.
- Back-to-back `round_valid` on consecutive cycles are each accepted in PLAY. A strobe arriving on the cycle after the winning round is in OVER and is ignored.
- There is no backpressure: the block is always ready.

## Structure
- Shared package `game_pkg`:
  - Result encodings (RES_NONE, RES_P1, RES_P2, RES_BOTH).
  - Winner encodings.
  - State enum (PLAY, OVER).
  - Seven-segment blank constant.
- Sub-module `seg7_decoder`: combinational, 4-bit hex in, 7-bit active-low segments out. It is reusable by other display blocks in the design.
- Everything else (FSM, counters, refresh mux) lives in `game_scoreboard`.

## Test plan
All scenarios use WIN_SCORE = 3 and REFRESH_DIV = 2.
- Release reset, then rounds 01, 01, 10, 01 → scores 3/1, `round_count` = 4, `match_over` = 1 one clock after the 4th strobe, `winner` = 01. A following round 10 leaves scores at 3/1.
- Rounds 11, 11, 11 → scores 3/3, `winner` = 11, `match_over` after the 3rd strobe. Neither digit is blanked.
- Rounds 10, 10, then `new_match` asserted together with a round 10 → scores 0/0, `round_count` = 0, state PLAY (round dropped).
- Assert reset for one clock after two rounds of 01 → all outputs at reset values next edge. A round 10 afterwards gives scores 0/1.
- Observe `an` for 16 clocks in PLAY → toggles every 4 clocks. `seg` matches the decoded score for the active digit on every cycle.
- Rounds 00 × 5 → `round_count` = 5, scores 0/0, `match_over` = 0.
